// File: rtl/raster_scan_tracker.sv
`default_nettype none
// ============================================================================
// Module   : raster_scan_tracker
// Purpose  : Pixel-stream stage that tags every accepted pixel with its raster
//            column/row and frame-boundary flags, and forwards it through a
//            single registered output slot (valid/ready on both sides).
// Ports    : clk_i        - clock, rising edge
//            reset_i      - asynchronous reset, active low
//            restart_i    - synchronous resync (drop slot, zero position)
//            valid_i/ready_o/data_i           - upstream pixel handshake
//            valid_o/ready_i/data_o           - downstream slot handshake
//            col_o/row_o  - raster position of data_o
//            sof_o/eol_o/eof_o - start-of-frame / end-of-line / end-of-frame
//            frame_cnt_o  - completed frames, modulo 256
// Revision : 1.0 - initial release
// ============================================================================
module raster_scan_tracker #(
    parameter int width_p        = 8,
    parameter int frame_width_p  = 320,
    parameter int frame_height_p = 240,
    parameter int col_width_p    = $clog2(frame_width_p),
    parameter int row_width_p    = $clog2(frame_height_p)
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   restart_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    input  logic [width_p-1:0]     data_i,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [width_p-1:0]     data_o,
    output logic [col_width_p-1:0] col_o,
    output logic [row_width_p-1:0] row_o,
    output logic                   sof_o,
    output logic                   eol_o,
    output logic                   eof_o,
    output logic [7:0]             frame_cnt_o
);

    // Last legal position, sized to the counters so comparisons never depend
    // on 2**width.
    localparam logic [col_width_p-1:0] COL_LAST = col_width_p'(frame_width_p - 1);
    localparam logic [row_width_p-1:0] ROW_LAST = row_width_p'(frame_height_p - 1);
    localparam logic [col_width_p-1:0] COL_ONE  = col_width_p'(1);
    localparam logic [row_width_p-1:0] ROW_ONE  = row_width_p'(1);

    // Position counters (position of the next pixel to be accepted)
    logic [col_width_p-1:0] col_q, col_d;
    logic [row_width_p-1:0] row_q, row_d;
    logic [7:0]             frame_cnt_q, frame_cnt_d;

    // Output slot
    logic                   valid_q, valid_d;
    logic [width_p-1:0]     data_q, data_d;
    logic [col_width_p-1:0] scol_q, scol_d;
    logic [row_width_p-1:0] srow_q, srow_d;
    logic                   sof_q, sof_d;
    logic                   eol_q, eol_d;
    logic                   eof_q, eof_d;

    logic accept;
    logic at_eol;
    logic at_eof;

    // A full slot may be drained and refilled in the same cycle.
    assign ready_o = !restart_i && (!valid_q || ready_i);
    assign accept  = valid_i && ready_o;
    assign at_eol  = (col_q == COL_LAST);
    assign at_eof  = at_eol && (row_q == ROW_LAST);

    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        frame_cnt_d = frame_cnt_q;
        valid_d     = valid_q;
        data_d      = data_q;
        scol_d      = scol_q;
        srow_d      = srow_q;
        sof_d       = sof_q;
        eol_d       = eol_q;
        eof_d       = eof_q;

        if (restart_i) begin
            // Resync wins over any handshake; frame count is preserved.
            col_d   = '0;
            row_d   = '0;
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
            data_d  = data_i;
            scol_d  = col_q;
            srow_d  = row_q;
            sof_d   = (col_q == '0) && (row_q == '0);
            eol_d   = at_eol;
            eof_d   = at_eof;

            if (at_eol) begin
                col_d = '0;
                if (row_q == ROW_LAST) begin
                    row_d       = '0;
                    frame_cnt_d = frame_cnt_q + 8'd1;
                end else begin
                    row_d = row_q + ROW_ONE;
                end
            end else begin
                col_d = col_q + COL_ONE;
            end
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            col_q       <= '0;
            row_q       <= '0;
            frame_cnt_q <= '0;
            valid_q     <= 1'b0;
            data_q      <= '0;
            scol_q      <= '0;
            srow_q      <= '0;
            sof_q       <= 1'b0;
            eol_q       <= 1'b0;
            eof_q       <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            frame_cnt_q <= frame_cnt_d;
            valid_q     <= valid_d;
            data_q      <= data_d;
            scol_q      <= scol_d;
            srow_q      <= srow_d;
            sof_q       <= sof_d;
            eol_q       <= eol_d;
            eof_q       <= eof_d;
        end
    end

    assign valid_o     = valid_q;
    assign data_o      = data_q;
    assign col_o       = scol_q;
    assign row_o       = srow_q;
    assign sof_o       = sof_q;
    assign eol_o       = eol_q;
    assign eof_o       = eof_q;
    assign frame_cnt_o = frame_cnt_q;

endmodule
`default_nettype wire
